// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared float unpack helpers: bias, class codes, datapath widths
package fp_pkg;

   typedef enum logic [2:0] {
      CLS_NORM = 3'd0,
      CLS_ZERO = 3'd1,
      CLS_SUBN = 3'd2,
      CLS_INF  = 3'd3,
      CLS_NAN  = 3'd4
   } fp_class_e;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Unbiased exponent width: room for the deepest subnormal and a sign bit.
   function automatic int fp_xw(input int exp_w);
      return exp_w + 2;
   endfunction

   function automatic int fp_lzw(input int man_w);
      return $clog2(man_w + 1);
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter; all-zero input yields MAN_W
module fp_lzc
   import fp_pkg::*;
#(
   parameter int MAN_W = 23,
   localparam int LZW  = fp_lzw(MAN_W)
) (
   input  logic [MAN_W-1:0] i_data,
   output logic [LZW-1:0]   o_count
);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      o_count = LZW'(MAN_W);
      for (int i = 0; i < MAN_W; i++) begin
         if (i_data[i]) begin
            o_count = LZW'(MAN_W - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fp_unpack_norm.sv
// rtl/fp_unpack_norm.sv - two-stage IEEE-754 unpacker: classify, count zeros,
// then left-normalise subnormals and unbias the exponent, with valid/ready flow.
module fp_unpack_norm
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter bit DAZ   = 1'b0,
   localparam int W    = 1 + EXP_W + MAN_W,
   localparam int XW   = fp_xw(EXP_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [XW-1:0]    out_exp,
   output logic [MAN_W:0]   out_mant,
   output logic             out_nan,
   output logic             out_snan,
   output logic             out_inf,
   output logic             out_zero,
   output logic             out_subn
);

   localparam int BIAS = fp_bias(EXP_W);
   localparam int LZW  = fp_lzw(MAN_W);

   logic             w_sign;
   logic [EXP_W-1:0] w_e;
   logic [MAN_W-1:0] w_m;
   logic             w_e_ones;
   logic             w_e_zero;
   logic             w_m_zero;
   fp_class_e        w_cls;
   logic [LZW-1:0]   w_lz;

   assign {w_sign, w_e, w_m} = in_data;
   assign w_e_ones = &w_e;
   assign w_e_zero = ~|w_e;
   assign w_m_zero = ~|w_m;

   always_comb begin
      w_cls = CLS_NORM;
      if (w_e_ones) begin
         w_cls = w_m_zero ? CLS_INF : CLS_NAN;
      end else if (w_e_zero) begin
         w_cls = w_m_zero ? CLS_ZERO : CLS_SUBN;
      end
   end

   fp_lzc #(.MAN_W(MAN_W)) u_lzc (
      .i_data  (w_m),
      .o_count (w_lz)
   );

   logic             r_s1_valid;
   logic             r_s2_valid;
   logic             w_s2_free;
   logic             w_s1_adv;
   logic             w_in_fire;

   // No skid buffer: in_ready sees out_ready combinationally through both stages.
   assign w_s2_free = ~r_s2_valid | out_ready;
   assign w_s1_adv  = r_s1_valid & w_s2_free;
   assign in_ready  = ~rst & (~r_s1_valid | w_s1_adv);
   assign w_in_fire = in_valid & in_ready;

   logic             r_s1_sign;
   logic [EXP_W-1:0] r_s1_exp;
   logic [MAN_W-1:0] r_s1_man;
   fp_class_e        r_s1_cls;
   logic [LZW-1:0]   r_s1_lz;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_exp   <= '0;
         r_s1_man   <= '0;
         r_s1_cls   <= CLS_NORM;
         r_s1_lz    <= '0;
      end else begin
         if (in_ready) begin
            r_s1_valid <= in_valid;
         end
         if (w_in_fire) begin
            r_s1_sign <= w_sign;
            r_s1_exp  <= w_e;
            r_s1_man  <= w_m;
            r_s1_cls  <= w_cls;
            r_s1_lz   <= w_lz;
         end
      end
   end

   logic [MAN_W:0]   w_man_ext;
   logic [XW-1:0]    w_exp_unb;
   logic [XW-1:0]    w_exp_subn;
   logic [XW-1:0]    w_s2_exp;
   logic [MAN_W:0]   w_s2_mant;
   logic             w_s2_nan;
   logic             w_s2_snan;
   logic             w_s2_inf;
   logic             w_s2_zero;
   logic             w_s2_subn;

   assign w_man_ext  = {1'b0, r_s1_man};
   assign w_exp_unb  = XW'(r_s1_exp) - XW'(BIAS);
   assign w_exp_subn = XW'(0) - XW'(BIAS) - XW'(r_s1_lz);

   always_comb begin
      w_s2_exp  = w_exp_unb;
      w_s2_mant = {1'b1, r_s1_man};
      case (r_s1_cls)
         CLS_ZERO: begin
            w_s2_exp  = '0;
            w_s2_mant = '0;
         end
         CLS_SUBN: begin
            if (DAZ) begin
               w_s2_exp  = '0;
               w_s2_mant = '0;
            end else begin
               // Shifting by lz+1 lands the leading one on the integer bit.
               w_s2_exp  = w_exp_subn;
               w_s2_mant = (w_man_ext << r_s1_lz) << 1;
            end
         end
         CLS_INF, CLS_NAN: begin
            w_s2_mant = w_man_ext;
         end
         default: ;
      endcase
   end

   assign w_s2_nan  = (r_s1_cls == CLS_NAN);
   assign w_s2_snan = w_s2_nan & ~r_s1_man[MAN_W-1];
   assign w_s2_inf  = (r_s1_cls == CLS_INF);
   assign w_s2_subn = (r_s1_cls == CLS_SUBN);
   assign w_s2_zero = (r_s1_cls == CLS_ZERO) | (DAZ & w_s2_subn);

   logic             r_s2_sign;
   logic [XW-1:0]    r_s2_exp;
   logic [MAN_W:0]   r_s2_mant;
   logic             r_s2_nan;
   logic             r_s2_snan;
   logic             r_s2_inf;
   logic             r_s2_zero;
   logic             r_s2_subn;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_sign  <= 1'b0;
         r_s2_exp   <= '0;
         r_s2_mant  <= '0;
         r_s2_nan   <= 1'b0;
         r_s2_snan  <= 1'b0;
         r_s2_inf   <= 1'b0;
         r_s2_zero  <= 1'b0;
         r_s2_subn  <= 1'b0;
      end else begin
         if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s1_adv) begin
            r_s2_sign <= r_s1_sign;
            r_s2_exp  <= w_s2_exp;
            r_s2_mant <= w_s2_mant;
            r_s2_nan  <= w_s2_nan;
            r_s2_snan <= w_s2_snan;
            r_s2_inf  <= w_s2_inf;
            r_s2_zero <= w_s2_zero;
            r_s2_subn <= w_s2_subn;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_sign  = r_s2_sign;
   assign out_exp   = r_s2_exp;
   assign out_mant  = r_s2_mant;
   assign out_nan   = r_s2_nan;
   assign out_snan  = r_s2_snan;
   assign out_inf   = r_s2_inf;
   assign out_zero  = r_s2_zero;
   assign out_subn  = r_s2_subn;

endmodule

// File: doc/fp_unpack_norm.md
# fp_unpack_norm

Parametrised, pipelined IEEE-754 unpacker for the fp_adder datapath. It splits a packed float into sign, unbiased signed exponent and a normalised significand with explicit leading one, and it classifies the input. Subnormals are left-normalised with a leading-zero count, so downstream alignment logic sees one significand format. It sits between the operand input registers and the exponent-compare/align stage, and uses a valid/ready handshake with full backpressure.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MAN_W`, default 23: stored mantissa field width.
- `DAZ`, default 0: when 1, subnormal inputs are treated as signed zero (denormals-are-zero).
- Derived, not overridable: `W = 1+EXP_W+MAN_W`; `BIAS = 2^(EXP_W-1)-1`; `XW = EXP_W+2`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input word present.
- `in_ready` output 1: block accepts the word this cycle.
- `in_data` input W: packed float {sign, exp, man}.
- `out_valid` output 1: result present.
- `out_ready` input 1: downstream accepts the result.
- `out_sign` output 1: sign bit, passed through unchanged.
- `out_exp` output XW: signed two's-complement unbiased exponent.
- `out_mant` output MAN_W+1: significand, MSB is the explicit integer bit.
- `out_nan`, `out_snan`, `out_inf`, `out_zero`, `out_subn` output 1 each: class flags.

## Operation
- Field rules:
  - e=all-ones and m≠0: NaN.
  - `out_snan` = NaN and m[MAN_W-1]=0.
  - e=all-ones and m=0: Inf.
  - e=0 and m=0: zero.
  - e=0 and m≠0: subnormal.
  - Otherwise: normal.
- Normal: `out_exp` = e−BIAS; `out_mant` = {1,m}.
- Subnormal (DAZ=0):
  - lz = leading zeros of m, range 0..MAN_W−1.
  - `out_mant` = ({0,m} << (lz+1)), truncated to MAN_W+1 bits. Its MSB is always 1.
  - `out_exp` = −BIAS−lz. For 32-bit, m=1 gives −149.
- Subnormal (DAZ=1): `out_zero`=1 and `out_subn`=1; `out_exp`=0, `out_mant`=0; sign is kept.
- Zero: `out_exp`=0, `out_mant`=0.
- Inf/NaN: `out_exp` = (2^EXP_W−1)−BIAS (128 for 32-bit); `out_mant` = {0,m}.
- Flag exclusivity:
  - Exactly one of nan/inf/zero/subn/normal holds, except that DAZ subnormals assert both zero and subn.
  - snan implies nan.
- Pipeline of 2 stages:
  - S1 registers the raw fields, the class flags and lz.
  - S2 registers the shifted significand, the exponent and the flags. S2 drives all `out_*` ports.
- Each stage holds a valid bit. A stage loads when it is empty or its contents advance in the same cycle.
  - `out_ready`=1 with S2 valid: S2 advances.
  - `in_ready` = ~S1.valid | (S1 advances). It is combinational from `out_ready`; there is no skid buffer.
- Results are in-order and lossless under any `out_ready` pattern. Data outputs are held stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Latency: 2 cycles from an accepted input to `out_valid`, with no stall.
- Throughput: 1 word/cycle while `out_ready`=1.
- Capacity: 2 words in flight. With `out_ready` held at 0, `in_ready` falls after 2 accepts.
- Reset:
  - Both valid bits are cleared, and all S1/S2 data registers are cleared to 0.
  - Reset values: `out_valid`=0 and every `out_*` data/flag = 0. `in_ready`=1 in the first cycle after reset is released.
  - While `rst`=1, no input is accepted; `in_ready`=0 during reset.
- Reset mid-stream: in-flight words are discarded and none is emitted afterwards.
- Simultaneous accept and emit with both stages full: S2←S1 and S1←in in the same edge, with no bubble.

## Structure
- The `fp_pkg` package holds:
  - `fp_bias(EXP_W)` and the class-encoding constants.
  - Width helpers shared with the align/add stages.
- One sub-module, `fp_lzc`: parametrised leading-zero counter.
  - Input MAN_W; output clog2(MAN_W+1), combinational.
  - Instantiated in S1.
- The shift and the exponent subtract are inline in S2.

## Test plan
- 0x3F800000 with `out_ready`=1 → 2 cycles later: sign 0, exp 0, mant 0x800000, no flags set.
- 0x00000001 → subn=1, exp −149 (9'h16B in the 10-bit field = 10'h36B), mant 0x800000. Also 0x00400000 → exp −127, mant 0x800000.
- 0x7FC00000 → nan=1, snan=0. 0x7F800001 → nan=1, snan=1. 0xFF800000 → inf=1, sign 1, exp 128.
- Backpressure:
  - Stimulus: 4 back-to-back words, `out_ready` low for 3 cycles, then high.
  - Required: `in_ready` drops after 2 accepts; all 4 words exit in order with no duplicates; outputs are stable while stalled.
- DAZ=1, input 0x80000001 → zero=1, subn=1, sign 1, exp 0, mant 0. Half-precision (EXP_W=5, MAN_W=10, DAZ=0), input 0x0001 → exp −24, mant 0x400.
- Reset is asserted with 2 words in flight → `out_valid` is 0 the next cycle and stays 0 until a new word is accepted.
